icache_controller: RTL and testbench
====================================

# icache_controller

Direct-mapped instruction cache between the CPU fetch stage and the block-read instruction memory. It services 32-bit fetches from 8 lines of 128 bits. On a miss it acts as the initiator of the memory's `read`/`busywait` block protocol and fills the line from the 16-byte `readdata` block. A `flush` input invalidates all lines so the cache can be cleared at a context switch.

## Interface
- `LINES`, 8: number of cache lines (power of two); index width = log2(LINES)
- `BLOCK_AW`, 28: memory block-address width (byte address [31:4])
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`
- `cpu_read`  in  1  fetch request
- `cpu_address`  in  32  byte address; bits [1:0] ignored
- `flush`  in  1  invalidate all lines (level, sampled per cycle)
- `cpu_readdata`  out  32  fetched instruction
- `cpu_busywait`  out  1  fetch not yet serviceable
- `mem_read`  out  1  block read request to instruction memory
- `mem_address`  out  `BLOCK_AW`  block address (byte address >> 4)
- `mem_readdata`  in  128  block data; byte k on bits [8k+7:8k]
- `mem_busywait`  in  1  memory busy; low in the last transfer cycle

## Operation
- Address split: offset [3:2] word select, index [6:4], tag [31:7] (25 bits).
- Per line: valid bit, 25-bit tag, 128-bit data. Hit = valid[index] && tag match.
- FSM states: IDLE, MEM_READ, FILL.
- IDLE:
  - `cpu_read` && hit: `cpu_busywait`=0 and `cpu_readdata` = word [offset] of the line, combinationally, same cycle.
  - `cpu_read` && miss: `cpu_busywait`=1; latch `cpu_address[31:4]` into `mem_address` and the index/tag into a miss register; go to MEM_READ.
  - `cpu_read` low: `cpu_busywait`=0; `cpu_readdata`=0.
- MEM_READ:
  - `mem_read`=1 and `mem_address` held constant.
  - While `mem_busywait`=1, stay.
  - On the edge where `mem_busywait`=0, go to FILL. The memory latches its final byte on this same edge, so data is not captured here.
- FILL:
  - `mem_read`=0.
  - On the edge, write `mem_readdata`, the tag, and valid=1 into the latched index; go to IDLE.
  - The re-presented fetch then hits.
- Outside IDLE, `cpu_busywait`=1 regardless of `cpu_read`.
- `cpu_readdata` is 0 whenever `cpu_busywait`=1 or `cpu_read`=0.
- Flush:
  - In IDLE, `flush`=1 clears all valid bits on the edge. It takes priority over miss detection in that cycle, and `cpu_busywait`=1 for that cycle.
  - During MEM_READ/FILL, `flush` sets a pending flag. The fill completes, then all valid bits (including the new line) are cleared on the first IDLE edge.
- Aborts: dropping `cpu_read` or changing `cpu_address` mid-miss does not abort. The fill completes, because the memory's transfer counter cannot be cancelled.

## Timing
- Reset (`reset`=0 at an edge):
  - State←IDLE; all valid bits←0; `mem_read`←0; `mem_address`←0; flush-pending←0.
  - With `cpu_read`=0, `cpu_busywait`=0 and `cpu_readdata`=0.
  - Data/tag arrays are not reset.
- Reset mid-miss: state returns to IDLE immediately and `mem_read` drops. System level resets the memory in the same cycle so its counter realigns.
- Hit latency: 0 cycles (combinational).
- Miss against a 16-byte memory:
  - Cycle 0: miss detected.
  - Cycles 1–16: MEM_READ, with `mem_busywait` high for 15 cycles and low in cycle 16.
  - Cycle 17: FILL.
  - Cycle 18: hit, instruction delivered.
  - Total: 18 cycles with `cpu_busywait`=1.
- `mem_read` is high for exactly the MEM_READ cycles. It is never high in IDLE or FILL.

## Structure
- Package `icache_pkg`:
  - state enum {IDLE, MEM_READ, FILL}
  - widths: TAG_W=25, IDX_W=3, OFF_W=2, LINE_W=128
- Sub-module `icache_line_store`: valid/tag/data arrays with one write port, a global valid clear, and a combinational read port addressed by index.
- FSM, miss register, and flush-pending logic live in `icache_controller`.

## Test plan
The bench uses the team's block-read instruction memory model (memory word 0 = 0xc1800013, word 1 = 0x00208093, byte 0x10 = 0x0000a2a3, byte 0x1c = 0x0050a103).

1. Reset, then fetch 0x00 → `cpu_busywait` high 18 cycles, `mem_read` high 16 cycles with `mem_address`=0, then `cpu_readdata`=0xc1800013.
2. Fetch 0x04 immediately after → hit in the same cycle, `cpu_readdata`=0x00208093, `mem_read` stays 0.
3. Fetch 0x10 then 0x1c → 0x10 misses and returns 0x0000a2a3 after 18 cycles; 0x1c hits with 0x0050a103.
4. Fetch 0x80 (index 0, new tag) then 0x00 → both miss, each taking 18 cycles; 0x00 returns 0xc1800013 again.
5. Pulse `flush` in IDLE, then fetch 0x04 → miss, 18-cycle refill. Pulse `flush` during MEM_READ → the fill completes, then the next fetch to that line misses.
6. Drive `reset`=0 at cycle 8 of a miss → `mem_read`=0 and `cpu_busywait`=0 next cycle; a subsequent fetch 0x00 misses and returns 0xc1800013.

Source files
------------

// File: rtl/icache_pkg.sv
// ============================================================================
// icache_pkg
// Shared types and widths for the direct-mapped instruction cache.
//   state_t      : controller FSM states
//   TAG_W/IDX_W/OFF_W/LINE_W : default field widths for 8 lines of 128 bits
//   select_word  : picks one 32-bit word out of a 128-bit line
// ============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        FILL     = 2'd2
    } state_t;

    localparam int TAG_W  = 25;
    localparam int IDX_W  = 3;
    localparam int OFF_W  = 2;
    localparam int LINE_W = 128;
    localparam int WORD_W = 32;

    // Word k of a line lives on bits [32k+31:32k] (byte k on [8k+7:8k]).
    function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                      input logic [OFF_W-1:0]  offset);
        return line[offset*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// ============================================================================
// icache_line_store
// Valid/tag/data storage for the direct-mapped instruction cache.
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   clear_all         : invalidate every line on the edge
//   write_en          : write write_tag/write_data into write_index, set valid
//   read_index        : combinational lookup address
//   read_valid/tag/data : contents of the addressed line, same cycle
// ============================================================================
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IW    = IDX_W,
    parameter int TW    = TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_all,
    input  logic              write_en,
    input  logic [IW-1:0]     write_index,
    input  logic [TW-1:0]     write_tag,
    input  logic [LINE_W-1:0] write_data,
    input  logic [IW-1:0]     read_index,
    output logic              read_valid,
    output logic [TW-1:0]     read_tag,
    output logic [LINE_W-1:0] read_data
);

    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    // A global clear always wins over a fill write; the controller never
    // requests both in one cycle, but the priority keeps flush semantics safe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (write_en) begin
            valid[write_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything, so they map onto plain RAM.
    always_ff @(posedge clock) begin
        if (write_en) begin
            tag_mem[write_index]  <= write_tag;
            data_mem[write_index] <= write_data;
        end
    end

    assign read_valid = valid[read_index];
    assign read_tag   = tag_mem[read_index];
    assign read_data  = data_mem[read_index];

endmodule

// File: rtl/icache_controller.sv
// ============================================================================
// icache_controller
// Direct-mapped instruction cache between the fetch stage and a block-read
// instruction memory. Hits are answered combinationally; a miss runs the
// memory's read/busywait protocol and fills the whole 16-byte line.
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   cpu_read       : fetch request
//   cpu_address    : byte address, bits [1:0] ignored
//   flush          : invalidate all lines (level)
//   cpu_readdata   : fetched instruction (0 unless delivering a hit)
//   cpu_busywait   : fetch cannot be serviced this cycle
//   mem_read       : block read request, high only in MEM_READ
//   mem_address    : block address (byte address >> 4)
//   mem_readdata   : 128-bit block, valid in the cycle after the last transfer
//   mem_busywait   : memory busy, low in its last transfer cycle
// ============================================================================
module icache_controller
    import icache_pkg::*;
#(
    parameter int LINES    = 8,
    parameter int BLOCK_AW = 28
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_read,
    input  logic [31:0]         cpu_address,
    input  logic                flush,
    output logic [31:0]         cpu_readdata,
    output logic                cpu_busywait,
    output logic                mem_read,
    output logic [BLOCK_AW-1:0] mem_address,
    input  logic [LINE_W-1:0]   mem_readdata,
    input  logic                mem_busywait
);

    localparam int IW = $clog2(LINES);
    localparam int TW = BLOCK_AW - IW;

    // Address fields of the incoming fetch.
    logic [OFF_W-1:0] offset;
    logic [IW-1:0]    index;
    logic [TW-1:0]    tag;

    assign offset = cpu_address[3:2];
    assign index  = cpu_address[4 +: IW];
    assign tag    = cpu_address[31 -: TW];

    state_t state, state_next;

    // Miss register: where the pending fill lands, independent of what the
    // CPU drives on cpu_address once the miss has started.
    logic [IW-1:0] miss_index;
    logic [TW-1:0] miss_tag;
    logic          flush_pending;

    logic              line_valid;
    logic [TW-1:0]     line_tag;
    logic [LINE_W-1:0] line_data;
    logic              hit;
    logic              clear_all;
    logic              write_en;
    logic              start_miss;

    icache_line_store #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_line_store (
        .clock       (clock),
        .reset       (reset),
        .clear_all   (clear_all),
        .write_en    (write_en),
        .write_index (miss_index),
        .write_tag   (miss_tag),
        .write_data  (mem_readdata),
        .read_index  (index),
        .read_valid  (line_valid),
        .read_tag    (line_tag),
        .read_data   (line_data)
    );

    assign hit = line_valid && (line_tag == tag);

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        cpu_busywait = 1'b0;
        cpu_readdata = '0;
        mem_read     = 1'b0;
        write_en     = 1'b0;
        clear_all    = 1'b0;
        start_miss   = 1'b0;

        unique case (state)
            IDLE: begin
                // A flush (fresh or deferred from a fill) owns this cycle:
                // lines are cleared on the edge and no lookup is trusted.
                if (flush || flush_pending) begin
                    clear_all    = 1'b1;
                    cpu_busywait = 1'b1;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_readdata = select_word(line_data, offset);
                    end else begin
                        cpu_busywait = 1'b1;
                        start_miss   = 1'b1;
                        state_next   = MEM_READ;
                    end
                end
            end

            MEM_READ: begin
                cpu_busywait = 1'b1;
                mem_read     = 1'b1;
                // The memory latches its last byte on this edge, so the
                // block is only stable in the following cycle.
                if (!mem_busywait) begin
                    state_next = FILL;
                end
            end

            FILL: begin
                cpu_busywait = 1'b1;
                write_en     = 1'b1;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: state and registers use non-blocking assignments so every flop
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            mem_address   <= '0;
            miss_index    <= '0;
            miss_tag      <= '0;
            flush_pending <= 1'b0;
        end else begin
            state <= state_next;

            if (start_miss) begin
                mem_address <= cpu_address[31 -: BLOCK_AW];
                miss_index  <= index;
                miss_tag    <= tag;
            end

            // A fill in flight cannot be cancelled, so a flush seen during
            // it is remembered and applied on the first IDLE edge.
            if (clear_all) begin
                flush_pending <= 1'b0;
            end else if (flush && (state != IDLE)) begin
                flush_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// ============================================================================
// tb_icache_controller
// Self-checking bench for icache_controller with a block-read instruction
// memory model (16 transfer cycles per block, busywait low in the last one).
// ============================================================================
module tb_icache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic [31:0]  cpu_address;
    logic         flush;
    logic [31:0]  cpu_readdata;
    logic         cpu_busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int total = 0;
    int bad   = 0;

    icache_controller #(
        .LINES    (8),
        .BLOCK_AW (28)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .cpu_address  (cpu_address),
        .flush        (flush),
        .cpu_readdata (cpu_readdata),
        .cpu_busywait (cpu_busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            32'h0000_0000: return 32'hc180_0013;
            32'h0000_0004: return 32'h0020_8093;
            32'h0000_0010: return 32'h0000_a2a3;
            32'h0000_001c: return 32'h0050_a103;
            default:       return {w[15:0] ^ 16'h5a5a, w[15:0]};
        endcase
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] blk;
        for (int k = 0; k < 4; k++) blk[32*k +: 32] = mem_word({b, 4'h0} + 32'(k * 4));
        return blk;
    endfunction

    logic [3:0] mcnt;
    assign mem_busywait = mem_read && (mcnt != 4'd15);

    always @(posedge clock) begin
        if (!reset) begin
            mcnt         <= '0;
            mem_readdata <= {4{32'hdead_beef}};
        end else if (mem_read) begin
            if (mcnt == 4'd15) begin
                mcnt         <= '0;
                mem_readdata <= mem_block(mem_address);
            end else begin
                mcnt <= mcnt + 4'd1;
            end
        end else begin
            mem_readdata <= {4{32'hdead_beef}};
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          busy;
        int          mcyc;
    } exp_t;

    typedef struct {
        bit          done;
        logic [31:0] data;
        int          busy;
        int          mcyc;
        bit          addr_ok;
        bit          quiet_ok;
    } obs_t;

    exp_t sb[$];

    // Issues one fetch (held until serviced), pushes its expectation and
    // reports what the DUT did. A miss costs 18 stalled cycles, 16 of them
    // with mem_read high; a hit costs none.
    task automatic fetch(input logic [31:0] addr, input bit miss, output obs_t o);
        exp_t e;
        e.addr = addr;
        e.data = mem_word(addr);
        e.busy = miss ? 18 : 0;
        e.mcyc = miss ? 16 : 0;
        sb.push_back(e);
        o.done = 0; o.busy = 0; o.mcyc = 0; o.addr_ok = 1; o.quiet_ok = 1; o.data = 'x;
        @(posedge clock); #1;
        cpu_read    = 1'b1;
        cpu_address = addr;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (mem_read) begin
                o.mcyc++;
                if (mem_address !== addr[31:4]) o.addr_ok = 0;
            end
            if (!cpu_busywait) begin
                o.done = 1;
                o.data = cpu_readdata;
                break;
            end
            o.busy++;
            if (cpu_readdata !== 32'h0) o.quiet_ok = 0;
            @(posedge clock); #1;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
        cpu_read = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; cpu_read = 1'b0; flush = 1'b0; cpu_address = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (cpu_busywait !== 1'b0) begin bad++; $display("FAIL reset_busywait got=%b want=0", cpu_busywait); end
        total++; if (cpu_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h want=0", cpu_readdata); end
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
        total++; if (mem_address !== 28'h0) begin bad++; $display("FAIL reset_mem_address got=%h want=0", mem_address); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        total++; if (cpu_busywait !== 1'b0 || mem_read !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle busywait=%b mem_read=%b want 0/0", cpu_busywait, mem_read);
        end
    endtask

    // Cold miss, same-line hit, miss then hit, conflict eviction and refetch.
    task automatic test_fill_and_hit();
        logic [31:0] addrs [6] = '{32'h00, 32'h04, 32'h10, 32'h1c, 32'h80, 32'h00};
        bit          misses[6] = '{1, 0, 1, 0, 1, 1};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            fetch(addrs[i], misses[i], o);
            e = sb.pop_front();
            total++; if (!o.done) begin bad++; $display("FAIL fetch_timeout addr=%h busywait never dropped", e.addr); end
            total++; if (o.data !== e.data) begin bad++; $display("FAIL fetch_data addr=%h got=%h want=%h", e.addr, o.data, e.data); end
            total++; if (o.busy != e.busy) begin bad++; $display("FAIL fetch_busy_cycles addr=%h got=%0d want=%0d", e.addr, o.busy, e.busy); end
            total++; if (o.mcyc != e.mcyc) begin bad++; $display("FAIL fetch_mem_read_cycles addr=%h got=%0d want=%0d", e.addr, o.mcyc, e.mcyc); end
            total++; if (!o.addr_ok) begin bad++; $display("FAIL fetch_mem_address addr=%h got=%h want=%h", e.addr, mem_address, e.addr[31:4]); end
            total++; if (!o.quiet_ok) begin bad++; $display("FAIL fetch_readdata_while_busy addr=%h got nonzero want=0", e.addr); end
        end
        idle_cycle();
    endtask

    task automatic test_flush_idle();
        obs_t o;
        exp_t e;
        @(posedge clock); #1;
        cpu_read = 1'b0;
        flush    = 1'b1;
        @(negedge clock);
        total++; if (cpu_busywait !== 1'b1) begin bad++; $display("FAIL flush_idle_busywait got=%b want=1", cpu_busywait); end
        @(posedge clock); #1;
        flush = 1'b0;
        fetch(32'h04, 1, o);
        e = sb.pop_front();
        total++; if (o.data !== e.data) begin bad++; $display("FAIL flush_refill_data got=%h want=%h", o.data, e.data); end
        total++; if (o.busy != e.busy) begin bad++; $display("FAIL flush_refill_busy got=%0d want=%0d", o.busy, e.busy); end
        idle_cycle();
    endtask

    // Flush during MEM_READ with the request also withdrawn: the fill still
    // runs to completion, and afterwards every line is invalid.
    task automatic test_flush_in_fill();
        obs_t o;
        exp_t e;
        int   mcyc = 0;
        @(posedge clock); #1;
        cpu_read    = 1'b1;
        cpu_address = 32'h20;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (mem_read) mcyc++;
            @(posedge clock); #1;
            if (i == 4) begin flush = 1'b1; cpu_read = 1'b0; end
            if (i == 5) flush = 1'b0;
        end
        total++; if (mcyc != 16) begin bad++; $display("FAIL flush_fill_mem_read_cycles got=%0d want=16", mcyc); end
        @(negedge clock);
        total++; if (cpu_busywait !== 1'b0) begin bad++; $display("FAIL flush_fill_settled_busywait got=%b want=0", cpu_busywait); end
        fetch(32'h20, 1, o);
        e = sb.pop_front();
        total++; if (o.data !== e.data) begin bad++; $display("FAIL flush_fill_refetch_data got=%h want=%h", o.data, e.data); end
        total++; if (o.busy != e.busy) begin bad++; $display("FAIL flush_fill_refetch_busy got=%0d want=%0d", o.busy, e.busy); end
        fetch(32'h04, 1, o);
        e = sb.pop_front();
        total++; if (o.busy != e.busy) begin bad++; $display("FAIL flush_fill_other_line_busy got=%0d want=%0d", o.busy, e.busy); end
        total++; if (o.data !== e.data) begin bad++; $display("FAIL flush_fill_other_line_data got=%h want=%h", o.data, e.data); end
        idle_cycle();
    endtask

    task automatic test_reset_mid_miss();
        obs_t o;
        exp_t e;
        @(posedge clock); #1;
        cpu_read    = 1'b1;
        cpu_address = 32'h40;
        repeat (8) begin @(posedge clock); #1; end
        @(negedge clock);
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL mid_miss_mem_read got=%b want=1", mem_read); end
        reset    = 1'b0;
        cpu_read = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mid_miss_mem_read got=%b want=0", mem_read); end
        total++; if (cpu_busywait !== 1'b0) begin bad++; $display("FAIL reset_mid_miss_busywait got=%b want=0", cpu_busywait); end
        @(posedge clock); #1;
        reset = 1'b1;
        fetch(32'h00, 1, o);
        e = sb.pop_front();
        total++; if (o.data !== e.data) begin bad++; $display("FAIL after_reset_data got=%h want=%h", o.data, e.data); end
        total++; if (o.busy != e.busy) begin bad++; $display("FAIL after_reset_busy got=%0d want=%0d", o.busy, e.busy); end
        total++; if (o.mcyc != e.mcyc) begin bad++; $display("FAIL after_reset_mem_read_cycles got=%0d want=%0d", o.mcyc, e.mcyc); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_fill_and_hit();
        test_flush_idle();
        test_flush_in_fill();
        test_reset_mid_miss();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
